// File: rtl/simple_processor.sv
// 16-bit multicycle accumulator processor: eight registers plus A, G and IR on one
// shared bus. Every instruction runs a fixed T0..T3 step sequence.
module simple_processor (
    input  logic        clock,
    input  logic        resetn,   // active-high despite the name
    input  logic [15:0] iin,
    output logic [15:0] bus
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_NAN = 3'b010,
        OP_OR  = 3'b011,
        OP_OUT = 3'b100,
        OP_LDI = 3'b101,
        OP_MV  = 3'b110,
        OP_NOP = 3'b111
    } opcode_e;

    step_e       step_q, step_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] a_q, a_d;
    logic [15:0] g_q, g_d;
    logic [15:0] r_q [8];

    opcode_e     opcode;
    logic [2:0]  rx, ry, rz;
    logic [15:0] imm_sext;
    logic        is_alu;
    logic [15:0] alu_result;
    logic        reg_we;
    logic [7:0]  wr_sel;

    assign opcode   = opcode_e'(ir_q[15:13]);
    assign rx       = ir_q[12:10];
    assign ry       = ir_q[9:7];
    assign rz       = ir_q[6:4];
    assign imm_sext = {{6{ir_q[9]}}, ir_q[9:0]};
    assign is_alu   = ~ir_q[15];

    // ALU combines the operand latched in A with whatever is on the bus at T2
    always_comb begin
        alu_result = 16'h0000;
        case (opcode)
            OP_ADD:  alu_result = a_q + bus;
            OP_SUB:  alu_result = a_q - bus;
            OP_NAN:  alu_result = ~(a_q & bus);
            OP_OR:   alu_result = a_q | bus;
            default: alu_result = 16'h0000;
        endcase
    end

    // Step sequencing, bus source selection and write enables
    always_comb begin
        step_d = step_e'(step_q + 2'd1);
        ir_d   = ir_q;
        a_d    = a_q;
        g_d    = g_q;
        bus    = 16'h0000;
        reg_we = 1'b0;
        case (step_q)
            T0: begin
                ir_d = iin;
            end
            T1: begin
                if (is_alu) begin
                    bus = r_q[ry];
                    a_d = bus;
                end else begin
                    case (opcode)
                        OP_LDI: begin
                            bus    = imm_sext;
                            reg_we = 1'b1;
                        end
                        OP_MV: begin
                            bus    = r_q[ry];
                            reg_we = 1'b1;
                        end
                        OP_OUT: bus = r_q[rx];
                        default: bus = 16'h0000;
                    endcase
                end
            end
            T2: begin
                if (is_alu) begin
                    bus = r_q[rz];
                    g_d = alu_result;
                end
            end
            T3: begin
                if (is_alu) begin
                    bus    = g_q;
                    reg_we = 1'b1;
                end
            end
            default: ;
        endcase
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_wr_sel
            assign wr_sel[gi] = reg_we && (rx == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (resetn) begin
            step_q <= T0;
            ir_q   <= 16'h0000;
            a_q    <= 16'h0000;
            g_q    <= 16'h0000;
            for (int i = 0; i < 8; i++) begin
                r_q[i] <= 16'h0000;
            end
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
            a_q    <= a_d;
            g_q    <= g_d;
            for (int i = 0; i < 8; i++) begin
                if (wr_sel[i]) begin
                    r_q[i] <= bus;
                end
            end
        end
    end

endmodule

// File: tb/tb_simple_processor.sv
// Directed bench for simple_processor: runs hand-assembled instructions and checks
// the bus at every step; register contents are observed through out/mv sequences.
module tb_simple_processor;

    logic        clock;
    logic        resetn;
    logic [15:0] iin;
    logic [15:0] bus;

    int checks;
    int errors;

    simple_processor dut (
        .clock  (clock),
        .resetn (resetn),
        .iin    (iin),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Called at the negedge inside a T0 cycle; returns at the negedge of the next T0.
    task automatic exec(input string tag, input logic [15:0] instr,
                        input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
        iin = instr;
        check({tag, ".T0"}, bus, 16'h0000);
        @(posedge clock); @(negedge clock);
        check({tag, ".T1"}, bus, e1);
        @(posedge clock); @(negedge clock);
        check({tag, ".T2"}, bus, e2);
        @(posedge clock); @(negedge clock);
        check({tag, ".T3"}, bus, e3);
        @(posedge clock); @(negedge clock);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        iin    = 16'h0000;
        resetn = 1'b1;
        @(posedge clock); @(posedge clock);
        @(negedge clock);
        check("reset.bus", bus, 16'h0000);
        resetn = 1'b0;

        exec("ldi_r6",  16'hB80F, 16'h000F, 16'h0000, 16'h0000);
        exec("ldi_r7",  16'hBCF0, 16'h00F0, 16'h0000, 16'h0000);
        exec("nan_r0",  16'h4370, 16'h000F, 16'h00F0, 16'hFFFF);
        exec("out_r0",  16'h8000, 16'hFFFF, 16'h0000, 16'h0000);
        exec("ldi_r1",  16'hA7FF, 16'hFFFF, 16'h0000, 16'h0000);
        exec("ldi_r2",  16'hA801, 16'h0001, 16'h0000, 16'h0000);
        exec("add_r3",  16'h0CA0, 16'hFFFF, 16'h0001, 16'h0000);
        exec("sub_r4",  16'h3110, 16'h0001, 16'hFFFF, 16'h0002);
        exec("out_r4",  16'h9000, 16'h0002, 16'h0000, 16'h0000);
        exec("out_r3",  16'h8C00, 16'h0000, 16'h0000, 16'h0000);
        exec("mv_r5",   16'hD600, 16'h0002, 16'h0000, 16'h0000);
        exec("out_r5",  16'h9400, 16'h0002, 16'h0000, 16'h0000);
        exec("nop",     16'hE000, 16'h0000, 16'h0000, 16'h0000);
        exec("nop_ones",16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
        exec("add_same",16'h1240, 16'h0002, 16'h0002, 16'h0004);
        exec("out_r4b", 16'h9000, 16'h0004, 16'h0000, 16'h0000);
        exec("or_r6",   16'h7B70, 16'h000F, 16'h00F0, 16'h00FF);
        exec("out_r6",  16'h9800, 16'h00FF, 16'h0000, 16'h0000);
        exec("out_r0b", 16'h8000, 16'hFFFF, 16'h0000, 16'h0000);

        // add r3,r6,r6 aborted by reset during T2
        iin = 16'h0F60;
        check("abort.T0", bus, 16'h0000);
        @(posedge clock); @(negedge clock);
        check("abort.T1", bus, 16'h00FF);
        @(posedge clock); @(negedge clock);
        check("abort.T2", bus, 16'h00FF);
        resetn = 1'b1;
        @(posedge clock); @(negedge clock);
        check("abort.rst", bus, 16'h0000);
        resetn = 1'b0;

        exec("post_out_r3", 16'h8C00, 16'h0000, 16'h0000, 16'h0000);
        exec("post_out_r6", 16'h9800, 16'h0000, 16'h0000, 16'h0000);
        exec("post_ldi_r3", 16'hAC05, 16'h0005, 16'h0000, 16'h0000);
        exec("post_out_r3b",16'h8C00, 16'h0005, 16'h0000, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
